// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state type, nibble width and nibble-count helper for the nibble-serial adder
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLE_W = 4;
  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction
endpackage

// File: rtl/cla_adder.sv
// cla_adder: 4-bit carry-lookahead slice (a, b, ci in; s, co out)
module cla_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;
  assign w_g = a & b;
  assign w_p = a ^ b;
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];
endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit add/sub through one shared 4-bit CLA slice, one nibble per clock, valid/ready in and out
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = nibbles(WIDTH);
  localparam int IW = $clog2(N);
  if (WIDTH % NIBBLE_W != 0 || WIDTH < 8) begin : g_width_check
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 8");
  end
  state_t                r_state;
  logic [WIDTH-1:0]      r_a, r_b, r_sum;
  logic                  r_c, r_cout, r_ovf;
  logic [IW-1:0]         r_idx;
  logic [NIBBLE_W-1:0]   w_s;
  logic                  w_co, w_last;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign w_last    = r_idx == IW'(N - 1);
  cla_adder u_slice (
    .a (r_a[NIBBLE_W*r_idx +: NIBBLE_W]),
    .b (r_b[NIBBLE_W*r_idx +: NIBBLE_W]),
    .ci(r_c),
    .s (w_s),
    .co(w_co)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
      r_c     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_c     <= sub | cin;
          r_idx   <= '0;
          r_sum   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_s;
          r_c   <= w_co;
          r_idx <= w_last ? r_idx : r_idx + 1'b1;
          if (w_last) begin
            r_cout  <= w_co;
            r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[NIBBLE_W-1] != r_a[WIDTH-1]);
            r_state <= DONE;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. It latches operands under a valid/ready handshake and ripples the slice carry through a register between cycles. It presents the result, carry-out and signed overflow under a second valid/ready handshake. It sits between a requesting datapath stage and its consumer wherever area matters more than single-cycle latency.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8 (elaboration error otherwise)
- clk  in  1  rising-edge clock; sole clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in for add; ignored when sub=1
- sub  in  1  1 = compute a − b (b inverted, carry-in forced 1)
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, registered
- cout  out  1  carry-out of MSB nibble (for subtract: 1 = no borrow)
- ovf  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready=1. On in_valid: latch a, effective b (sub ? ~b : b), carry register ← (sub ? 1 : cin); clear nibble index; clear sum → RUN. Without in_valid, remain in IDLE.
- RUN: each cycle, feed nibble[idx] of A and effective B plus the carry register to the slice. Write slice S into sum[4·idx+3:4·idx]; carry register ← slice carry-out; idx++.
  - On last nibble (idx = WIDTH/4−1): cout ← slice carry-out; ovf ← (A_msb == Beff_msb) && (S_msb != A_msb) → DONE.
- DONE: out_valid=1; sum/cout/ovf stable. On out_ready → IDLE. Without out_ready, hold indefinitely; in_ready stays 0 (no overlap of accept and deliver).
- Inputs a, b, cin, sub are sampled only on the accept cycle; later changes have no effect.
- Arithmetic is modulo 2^WIDTH; the index counter is $clog2(WIDTH/4) bits wide and never wraps past the last nibble.
- rst in any state (including mid-RUN) aborts the operation. The next cycle is IDLE with all outputs at reset values; no partial result is ever presented.

## Timing
- Reset values: in_ready=1 (IDLE decode), out_valid=0, sum=0, cout=0, ovf=0.
- Accept on cycle t (in_valid & in_ready). RUN spans cycles t+1 … t+N, where N = WIDTH/4. out_valid rises in cycle t+N+1.
- With out_ready held high: out_valid lasts exactly 1 cycle, in_ready returns in t+N+2, and the next accept can occur at t+N+2. Peak throughput is one operation per N+2 cycles.
- in_ready and out_valid are pure state decodes: no combinational path from any input.
- The per-cycle critical path is one slice plus the carry register mux.

## Structure
- Shared package cla_pkg: state enum typedef (IDLE/RUN/DONE), NIBBLE_W=4 constant, and a function returning WIDTH/4 nibble count.
- One sub-module: the existing 4-bit slice cla_adder, instantiated once. No second adder.
- The remainder is the FSM, operand/sum registers, carry register and nibble counter.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x0FFF, cin=0, accept at t → sum=0x2233, cout=0, ovf=0; out_valid first high at t+5, in_ready high again at t+6.
- Carry wrap: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Subtract a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → sum/cout/ovf and out_valid stable, in_ready=0 throughout, and in_valid pulses are not accepted. Then out_ready=1 → IDLE next cycle.
- Reset mid-RUN: assert rst on the 2nd RUN cycle → out_valid never rises for that request, sum=0, and in_ready=1 the cycle after rst deasserts. A new add 0x0001+0x0001 then completes to 0x0002.
